// File: rtl/rc4_crack_controller.sv
// RC4 key-search sequencer: drives init / KSA / PRGA phases per candidate key,
// owns the S and D RAM port muxes, then scans the decrypted bytes for plaintext.
module rc4_crack_controller #(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3FFFFF,
    parameter int                   MSG_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 phase_rst,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 prga_start,
    input  logic                 init_finish,
    input  logic                 ksa_finish,
    input  logic                 prga_finish,
    input  logic [7:0]           init_addr_S,
    input  logic [7:0]           ksa_addr_S,
    input  logic [7:0]           prga_addr_S,
    input  logic [7:0]           init_data_S,
    input  logic [7:0]           ksa_data_S,
    input  logic [7:0]           prga_data_S,
    input  logic                 init_wren_S,
    input  logic                 ksa_wren_S,
    input  logic                 prga_wren_S,
    output logic [7:0]           s_address,
    output logic [7:0]           s_data,
    output logic                 s_wren,
    input  logic [4:0]           prga_addr_D,
    input  logic [7:0]           prga_data_D,
    input  logic                 prga_wren_D,
    output logic [4:0]           d_address,
    output logic [7:0]           d_data,
    output logic                 d_wren,
    input  logic [7:0]           q_D,
    output logic                 busy,
    output logic                 found,
    output logic                 fail
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RESET_SUBS,
        ST_INIT_RUN,
        ST_KSA_RUN,
        ST_PRGA_RUN,
        ST_CHECK_ADDR,
        ST_CHECK_WAIT,
        ST_CHECK_EVAL,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_FAIL
    } state_t;

    localparam logic [4:0] IDX_LAST = 5'(MSG_LEN - 1);

    state_t               state_q;
    state_t               state_d;
    logic [KEY_WIDTH-1:0] key_q;
    logic [4:0]           idx_q;
    logic                 byte_ok;
    logic                 idx_last;
    logic                 key_last;

    // Printable plaintext: lowercase letters or space
    assign byte_ok  = (q_D >= 8'h61 && q_D <= 8'h7A) || (q_D == 8'h20);
    assign idx_last = (idx_q == IDX_LAST);
    assign key_last = (key_q == KEY_LAST);
    assign key      = key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_START;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_PRGA_RUN:   idx_q <= 5'd0;
                ST_CHECK_EVAL: if (byte_ok && !idx_last) idx_q <= idx_q + 5'd1;
                ST_NEXT_KEY:   if (!key_last) key_q <= key_q + KEY_WIDTH'(1);
                default:       ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_rst  = 1'b0;
        init_start = 1'b0;
        ksa_start  = 1'b0;
        prga_start = 1'b0;
        s_address  = 8'd0;
        s_data     = 8'd0;
        s_wren     = 1'b0;
        d_address  = 5'd0;
        d_data     = 8'd0;
        d_wren     = 1'b0;
        busy       = 1'b1;
        found      = 1'b0;
        fail       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_RESET_SUBS;
            end
            ST_RESET_SUBS: begin
                phase_rst = 1'b1;
                state_d   = ST_INIT_RUN;
            end
            ST_INIT_RUN: begin
                init_start = 1'b1;
                s_address  = init_addr_S;
                s_data     = init_data_S;
                s_wren     = init_wren_S;
                if (init_finish) state_d = ST_KSA_RUN;
            end
            ST_KSA_RUN: begin
                ksa_start = 1'b1;
                s_address = ksa_addr_S;
                s_data    = ksa_data_S;
                s_wren    = ksa_wren_S;
                if (ksa_finish) state_d = ST_PRGA_RUN;
            end
            ST_PRGA_RUN: begin
                prga_start = 1'b1;
                s_address  = prga_addr_S;
                s_data     = prga_data_S;
                s_wren     = prga_wren_S;
                d_address  = prga_addr_D;
                d_data     = prga_data_D;
                d_wren     = prga_wren_D;
                if (prga_finish) state_d = ST_CHECK_ADDR;
            end
            ST_CHECK_ADDR: begin
                d_address = idx_q;
                state_d   = ST_CHECK_WAIT;
            end
            ST_CHECK_WAIT: begin
                d_address = idx_q;
                state_d   = ST_CHECK_EVAL;
            end
            ST_CHECK_EVAL: begin
                d_address = idx_q;
                if (!byte_ok)      state_d = ST_NEXT_KEY;
                else if (idx_last) state_d = ST_FOUND;
                else               state_d = ST_CHECK_ADDR;
            end
            ST_NEXT_KEY: begin
                state_d = key_last ? ST_FAIL : ST_RESET_SUBS;
            end
            ST_FOUND: begin
                busy  = 1'b0;
                found = 1'b1;
            end
            ST_FAIL: begin
                busy = 1'b0;
                fail = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_crack_controller.sv
// Bench for rc4_crack_controller: mock phase FSMs, D RAM model and a
// key-search reference model over a plaintext table indexed by key.
module tb_rc4_crack_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst[2], start[2], phase_rst[2];
    logic        init_start[2], ksa_start[2], prga_start[2];
    logic        init_finish[2], ksa_finish[2], prga_finish[2];
    logic [23:0] key[2];
    logic [7:0]  init_addr_S[2], ksa_addr_S[2], prga_addr_S[2];
    logic [7:0]  init_data_S[2], ksa_data_S[2], prga_data_S[2];
    logic        init_wren_S[2], ksa_wren_S[2], prga_wren_S[2];
    logic [7:0]  s_address[2], s_data[2];
    logic        s_wren[2];
    logic [4:0]  prga_addr_D[2], d_address[2];
    logic [7:0]  prga_data_D[2], d_data[2], q_D[2];
    logic        prga_wren_D[2], d_wren[2];
    logic        busy[2], found[2], fail[2];

    logic [7:0]  dram[2][32];
    logic [7:0]  ptab[8][32];

    int  cnt_i[2], cnt_k[2], wcnt[2], dly_i[2], dly_k[2];
    bit  done_i[2], done_k[2], done_p[2];
    int  exp_ph[2];
    bit  mock_en[2];
    bit  probe[2], probe_armed[2], probe_done[2];
    int  cc[2], as_sum[2], pr[2];

    rc4_crack_controller u_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .key(key[0]),
        .phase_rst(phase_rst[0]), .init_start(init_start[0]),
        .ksa_start(ksa_start[0]), .prga_start(prga_start[0]),
        .init_finish(init_finish[0]), .ksa_finish(ksa_finish[0]),
        .prga_finish(prga_finish[0]),
        .init_addr_S(init_addr_S[0]), .ksa_addr_S(ksa_addr_S[0]),
        .prga_addr_S(prga_addr_S[0]), .init_data_S(init_data_S[0]),
        .ksa_data_S(ksa_data_S[0]), .prga_data_S(prga_data_S[0]),
        .init_wren_S(init_wren_S[0]), .ksa_wren_S(ksa_wren_S[0]),
        .prga_wren_S(prga_wren_S[0]),
        .s_address(s_address[0]), .s_data(s_data[0]), .s_wren(s_wren[0]),
        .prga_addr_D(prga_addr_D[0]), .prga_data_D(prga_data_D[0]),
        .prga_wren_D(prga_wren_D[0]),
        .d_address(d_address[0]), .d_data(d_data[0]), .d_wren(d_wren[0]),
        .q_D(q_D[0]), .busy(busy[0]), .found(found[0]), .fail(fail[0])
    );

    rc4_crack_controller #(
        .KEY_START(24'h000005), .KEY_LAST(24'h000005)
    ) u_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .key(key[1]),
        .phase_rst(phase_rst[1]), .init_start(init_start[1]),
        .ksa_start(ksa_start[1]), .prga_start(prga_start[1]),
        .init_finish(init_finish[1]), .ksa_finish(ksa_finish[1]),
        .prga_finish(prga_finish[1]),
        .init_addr_S(init_addr_S[1]), .ksa_addr_S(ksa_addr_S[1]),
        .prga_addr_S(prga_addr_S[1]), .init_data_S(init_data_S[1]),
        .ksa_data_S(ksa_data_S[1]), .prga_data_S(prga_data_S[1]),
        .init_wren_S(init_wren_S[1]), .ksa_wren_S(ksa_wren_S[1]),
        .prga_wren_S(prga_wren_S[1]),
        .s_address(s_address[1]), .s_data(s_data[1]), .s_wren(s_wren[1]),
        .prga_addr_D(prga_addr_D[1]), .prga_data_D(prga_data_D[1]),
        .prga_wren_D(prga_wren_D[1]),
        .d_address(d_address[1]), .d_data(d_data[1]), .d_wren(d_wren[1]),
        .q_D(q_D[1]), .busy(busy[1]), .found(found[1]), .fail(fail[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_valid(input logic [7:0] b);
        return b inside {[8'h61:8'h7A], 8'h20};
    endfunction

    function automatic logic [7:0] rnd_valid();
        int r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'h61 + 8'(r);
    endfunction

    function automatic logic [7:0] rnd_bad();
        logic [7:0] bad[7] = '{8'h60, 8'h7B, 8'h1F, 8'h21, 8'h41, 8'h00, 8'hFF};
        return bad[$urandom_range(0, 6)];
    endfunction

    function automatic int first_bad(input int k);
        for (int j = 0; j < 32; j++)
            if (!is_valid(ptab[k][j])) return j;
        return 32;
    endfunction

    // D RAM: one-cycle registered read
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (d_wren[i]) dram[i][d_address[i]] <= d_data[i];
            q_D[i] <= dram[i][d_address[i]];
        end
    end

    // Per-cycle mux checks, then mock phase FSMs, then expected-phase tracker
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [2:0]  e3;
            logic [31:0] es, ed;
            if (rst[i]) exp_ph[i] = 0;
            if (mock_en[i]) begin
                e3 = (exp_ph[i] == 1) ? 3'b100 : (exp_ph[i] == 2) ? 3'b010 :
                     (exp_ph[i] == 3) ? 3'b001 : 3'b000;
                chk("starts", {29'b0, init_start[i], ksa_start[i],
                               prga_start[i]}, {29'b0, e3});
                case (exp_ph[i])
                    1: es = {init_addr_S[i], init_data_S[i], 15'b0,
                             init_wren_S[i]};
                    2: es = {ksa_addr_S[i], ksa_data_S[i], 15'b0,
                             ksa_wren_S[i]};
                    3: es = {prga_addr_S[i], prga_data_S[i], 15'b0,
                             prga_wren_S[i]};
                    default: es = 32'b0;
                endcase
                chk("s_mux", {s_address[i], s_data[i], 15'b0, s_wren[i]}, es);
                if (exp_ph[i] == 3) begin
                    ed = {3'b0, prga_addr_D[i], prga_data_D[i], 15'b0,
                          prga_wren_D[i]};
                    chk("d_mux", {3'b0, d_address[i], d_data[i], 15'b0,
                                  d_wren[i]}, ed);
                end else begin
                    chk("d_idle", {23'b0, d_data[i], d_wren[i]}, 32'b0);
                end
                if (probe_armed[i]) begin
                    chk("probe_addr", 32'(s_address[i]), 32'hA5);
                    chk("probe_wren", 32'(s_wren[i]), 32'h0);
                    probe_armed[i] = 0;
                    probe_done[i]  = 1;
                end
                if (busy[i] && exp_ph[i] == 0 && !phase_rst[i]) begin
                    cc[i]++;
                    as_sum[i] += int'(d_address[i]);
                end
                if (phase_rst[i]) pr[i]++;

                init_addr_S[i] = 8'($urandom); init_data_S[i] = 8'($urandom);
                ksa_addr_S[i]  = 8'($urandom); ksa_data_S[i]  = 8'($urandom);
                prga_addr_S[i] = 8'($urandom); prga_data_S[i] = 8'($urandom);
                init_wren_S[i] = 1'($urandom); ksa_wren_S[i]  = 1'($urandom);
                prga_wren_S[i] = 1'($urandom);
                if (probe[i] && exp_ph[i] == 2 && !probe_done[i]
                    && !probe_armed[i]) begin
                    ksa_addr_S[i]  = 8'hA5;
                    init_wren_S[i] = 1'b1;
                    prga_wren_S[i] = 1'b1;
                    ksa_wren_S[i]  = 1'b0;
                    probe_armed[i] = 1;
                end

                if (phase_rst[i]) begin
                    cnt_i[i] = 0; cnt_k[i] = 0; wcnt[i] = 0;
                    done_i[i] = 0; done_k[i] = 0; done_p[i] = 0;
                    init_finish[i] = 0; ksa_finish[i] = 0;
                    prga_finish[i] = 0; prga_wren_D[i] = 0;
                end else begin
                    if (init_start[i] && !done_i[i]) begin
                        cnt_i[i]++;
                        if (cnt_i[i] >= dly_i[i]) begin
                            init_finish[i] = 1; done_i[i] = 1;
                        end
                    end
                    if (ksa_start[i] && !done_k[i]) begin
                        cnt_k[i]++;
                        if (cnt_k[i] >= dly_k[i]) begin
                            ksa_finish[i] = 1; done_k[i] = 1;
                        end
                    end
                    if (prga_start[i] && !done_p[i]) begin
                        if (wcnt[i] < 32) begin
                            prga_addr_D[i] = 5'(wcnt[i]);
                            prga_data_D[i] = ptab[int'(key[i][2:0])][wcnt[i]];
                            prga_wren_D[i] = 1;
                            wcnt[i]++;
                        end else begin
                            prga_wren_D[i] = 0;
                            prga_finish[i] = 1;
                            done_p[i]      = 1;
                        end
                    end else begin
                        prga_wren_D[i] = 0;
                    end
                end

                if (rst[i])                                exp_ph[i] = 0;
                else if (phase_rst[i])                     exp_ph[i] = 1;
                else if (exp_ph[i] == 1 && init_finish[i]) exp_ph[i] = 2;
                else if (exp_ph[i] == 2 && ksa_finish[i])  exp_ph[i] = 3;
                else if (exp_ph[i] == 3 && prga_finish[i]) exp_ph[i] = 0;
            end else begin
                init_finish[i] = 1; ksa_finish[i] = 1; prga_finish[i] = 1;
                init_addr_S[i] = 8'hFF; ksa_addr_S[i] = 8'hFF;
                prga_addr_S[i] = 8'hFF; init_data_S[i] = 8'hFF;
                ksa_data_S[i]  = 8'hFF; prga_data_S[i] = 8'hFF;
                init_wren_S[i] = 1; ksa_wren_S[i] = 1; prga_wren_S[i] = 1;
                prga_addr_D[i] = 5'h1F; prga_data_D[i] = 8'hFF;
                prga_wren_D[i] = 1;
            end
        end
    end

    task automatic rst_pulse(input int i);
        @(posedge clk); #1;
        rst[i] = 1; start[i] = 0;
        @(posedge clk); #1;
        rst[i] = 0;
    endtask

    // Reference: walk keys in order, read bytes until the first invalid one
    task automatic run(input int i, input logic [23:0] ks, input logic [23:0] kl);
        int reads = 0, nk = 0, asum = 0, resets = 0, cyc = 0, j, n;
        bit fnd = 0;
        logic [23:0] k = ks;
        for (int g = 0; g < 64; g++) begin
            j = first_bad(int'(k[2:0]));
            resets++;
            n = (j == 32) ? 32 : j + 1;
            reads += n;
            for (int t = 0; t < n; t++) asum += 3 * t;
            if (j == 32) begin
                fnd = 1;
                break;
            end
            nk++;
            if (k == kl) break;
            k++;
        end
        cc[i] = 0; as_sum[i] = 0; pr[i] = 0;
        @(posedge clk); #1;
        start[i] = 1;
        while (!(found[i] || fail[i]) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout", 32'(cyc < 6000), 32'h1);
        chk("found", 32'(found[i]), 32'(fnd));
        chk("fail", 32'(fail[i]), 32'(!fnd));
        chk("key", 32'(key[i]), 32'(k));
        chk("busy_end", 32'(busy[i]), 32'h0);
        chk("check_cycles", 32'(cc[i]), 32'(3 * reads + nk));
        chk("addr_sum", 32'(as_sum[i]), 32'(asum));
        chk("phase_rst_cnt", 32'(pr[i]), 32'(resets));
        rst_pulse(i);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; start[i] = 1; mock_en[i] = 0; exp_ph[i] = 0;
            dly_i[i] = 3; dly_k[i] = 3; probe[i] = 0;
            probe_armed[i] = 0; probe_done[i] = 0;
            init_finish[i] = 1; ksa_finish[i] = 1; prga_finish[i] = 1;
            init_addr_S[i] = 8'hFF; ksa_addr_S[i] = 8'hFF;
            prga_addr_S[i] = 8'hFF; init_data_S[i] = 8'hFF;
            ksa_data_S[i] = 8'hFF; prga_data_S[i] = 8'hFF;
            init_wren_S[i] = 1; ksa_wren_S[i] = 1; prga_wren_S[i] = 1;
            prga_addr_D[i] = 5'h1F; prga_data_D[i] = 8'hFF; prga_wren_D[i] = 1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy[i]), 32'h0);
            chk("rst_found", 32'(found[i]), 32'h0);
            chk("rst_fail", 32'(fail[i]), 32'h0);
            chk("rst_s_wren", 32'(s_wren[i]), 32'h0);
            chk("rst_d_wren", 32'(d_wren[i]), 32'h0);
            chk("rst_key", 32'(key[i]), (i == 0) ? 32'h0 : 32'h5);
            chk("rst_ctl", {28'b0, phase_rst[i], init_start[i],
                            ksa_start[i], prga_start[i]}, 32'h0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; mock_en[i] = 1; rst[i] = 0;
        end

        // Key 0 all 'a', KSA mux probe
        for (int j = 0; j < 32; j++) ptab[0][j] = 8'h61;
        probe[0] = 1; dly_k[0] = 4;
        run(0, 24'h0, 24'h3FFFFF);
        chk("probe_seen", 32'(probe_done[0]), 32'h1);
        probe[0] = 0;

        // Key 0 rejected on first byte, key 1 all spaces
        for (int j = 0; j < 32; j++) begin
            ptab[0][j] = rnd_valid();
            ptab[1][j] = 8'h20;
        end
        ptab[0][0] = 8'h41;
        run(0, 24'h0, 24'h3FFFFF);

        // Randomized tables and phase latencies
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < 32; j++) ptab[k][j] = rnd_valid();
                if (k < 7 && $urandom_range(0, 3) != 0)
                    ptab[k][$urandom_range(0, 31)] = rnd_bad();
            end
            dly_i[0] = $urandom_range(1, 5);
            dly_k[0] = $urandom_range(1, 5);
            run(0, 24'h0, 24'h3FFFFF);
        end

        // Reset during PRGA of key 3, then rerun from scratch
        dly_i[0] = 3; dly_k[0] = 3;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 32; j++) ptab[k][j] = rnd_valid();
            if (k < 3) ptab[k][$urandom_range(0, 31)] = rnd_bad();
        end
        @(posedge clk); #1;
        start[0] = 1;
        cyc = 0;
        while (!(key[0] == 24'h3 && prga_start[0]) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_key3", 32'(cyc < 3000), 32'h1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst[0] = 1; start[0] = 0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy[0]), 32'h0);
        chk("mid_rst_key", 32'(key[0]), 32'h0);
        chk("mid_rst_d_wren", 32'(d_wren[0]), 32'h0);
        chk("mid_rst_s_wren", 32'(s_wren[0]), 32'h0);
        @(posedge clk); #1;
        rst[0] = 0;
        run(0, 24'h0, 24'h3FFFFF);

        // Single-key range, last byte out of range by one
        for (int j = 0; j < 32; j++) ptab[5][j] = rnd_valid();
        ptab[5][31] = 8'h7B;
        run(1, 24'h5, 24'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
